// File: rtl/memreg_responder.sv
// Bus responder serving a DEPTH x 8 scratch memory plus CTRL/XFERCNT/ID registers,
// with programmable wait states. Optional error responses: define MEMREG_ERR_RESP_EN.
`timescale 1ns/1ps

module memreg_responder #(
  parameter int         DEPTH         = 16,
  parameter logic [3:0] WAIT_DEFAULT  = 4'd0,
  parameter logic [7:0] UNMAPPED_DATA = 8'hEE
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       trans,
  input  logic       write,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  output logic       readyout,
  output logic [7:0] rdata,
  output logic       err,
  output logic [1:0] dbg_state
);

  localparam int         IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_L = 9'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_write;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic [3:0] r_wcnt;
  logic [3:0] r_ctrl;
  logic [7:0] r_xfercnt;
  logic [7:0] r_rdata;
  logic       r_err;
  logic [7:0] r_mem [DEPTH];

  logic       w_cur_write;
  logic [7:0] w_cur_addr;
  logic [7:0] w_cur_data;
  logic       w_is_mem;
  logic [7:0] w_rd_data;
  logic       w_err;
  logic       w_commit;

  // With zero wait states the commit edge is the sampling edge, so the
  // transfer fields come straight from the bus rather than the latches.
  assign w_cur_write = (r_state == S_IDLE) ? write : r_write;
  assign w_cur_addr  = (r_state == S_IDLE) ? waddr : r_addr;
  assign w_cur_data  = (r_state == S_IDLE) ? wdata : r_wdata;
  assign w_is_mem    = ({1'b0, w_cur_addr} < DEPTH_L);

  always_comb begin
    w_rd_data = UNMAPPED_DATA;
    if (w_is_mem) begin
      w_rd_data = r_mem[w_cur_addr[IW-1:0]];
    end else begin
      case (w_cur_addr)
        8'h10:   w_rd_data = {4'b0000, r_ctrl};
        8'h11:   w_rd_data = r_xfercnt;
        8'h12:   w_rd_data = 8'h5A;
        default: w_rd_data = UNMAPPED_DATA;
      endcase
    end
  end

`ifdef MEMREG_ERR_RESP_EN
  assign w_err = (!w_is_mem && (w_cur_addr != 8'h10) && (w_cur_addr != 8'h11) &&
                  (w_cur_addr != 8'h12)) || (w_cur_write && (w_cur_addr == 8'h12));
`else
  assign w_err = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (trans) w_next = (r_ctrl == 4'd0) ? S_RESP : S_WAIT;
      S_WAIT: if (r_wcnt == 4'd1) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // RESP always exits after one cycle, so this is only true on the entering edge.
  assign w_commit = (w_next == S_RESP);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_write   <= 1'b0;
      r_addr    <= 8'h00;
      r_wdata   <= 8'h00;
      r_wcnt    <= 4'd0;
      r_ctrl    <= WAIT_DEFAULT;
      r_xfercnt <= 8'h00;
      r_rdata   <= 8'h00;
      r_err     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && trans) begin
        r_write <= write;
        r_addr  <= waddr;
        r_wdata <= wdata;
        r_wcnt  <= r_ctrl;
      end else if (r_state == S_WAIT) begin
        r_wcnt <= r_wcnt - 4'd1;
      end
      if (w_commit) begin
        r_rdata <= w_cur_write ? w_cur_data : w_rd_data;
        r_err   <= w_err;
        if (w_cur_write && w_cur_addr == 8'h11) r_xfercnt <= 8'h00;
        else                                    r_xfercnt <= r_xfercnt + 8'd1;
        if (w_cur_write && w_is_mem) r_mem[w_cur_addr[IW-1:0]] <= w_cur_data;
        if (w_cur_write && w_cur_addr == 8'h10) r_ctrl <= w_cur_data[3:0];
      end
    end
  end

  assign readyout  = (r_state == S_RESP);
  assign rdata     = r_rdata;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_memreg_responder.sv
// Directed bench for memreg_responder: drivers push {err, rdata} expectations,
// a negedge monitor pops them on every readyout pulse.
`timescale 1ns/1ps

module tb_memreg_responder;

`ifdef MEMREG_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clock;
  logic       rst_n;
  logic       trans;
  logic       write;
  logic [7:0] waddr;
  logic [7:0] wdata;
  logic       readyout;
  logic [7:0] rdata;
  logic       err;
  logic [1:0] dbg_state;

  logic [8:0] exp_q[$];
  int         n_cmp;
  int         n_fail;
  logic       prev_rdy;

  memreg_responder dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .trans     (trans),
    .write     (write),
    .waddr     (waddr),
    .wdata     (wdata),
    .readyout  (readyout),
    .rdata     (rdata),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1;
    rst_n = 1'b0;
    trans = 1'b0;
    #2;
    @(posedge clock); #1;
    rst_n = 1'b1;
  endtask

  // Driver: one transfer, expected response pushed, latency checked in cycles
  task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] exp_d, input logic err_case, input int lat);
    int cyc;
    bit seen;
    @(posedge clock); #1;
    trans = 1'b1;
    write = w;
    waddr = a;
    wdata = d;
    exp_q.push_back({err_case & ERR_EN, exp_d});
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
      if (readyout) seen = 1'b1;
    end
    trans = 1'b0;
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: addr 0x%0h no readyout within 40 cycles", a);
    end else begin
      check("latency", cyc, lat);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (!rst_n) begin
      prev_rdy = 1'b0;
    end else begin
      if (readyout) begin
        n_cmp++;
        if (prev_rdy) begin
          n_fail++;
          $display("FAIL pulse_width: readyout high 2 cycles, required 1");
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_resp: rdata 0x%0h err %0b, no response expected", rdata, err);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          if ({err, rdata} !== e) begin
            n_fail++;
            $display("FAIL resp: got err %0b rdata 0x%0h expected err %0b rdata 0x%0h",
                     err, rdata, e[8], e[7:0]);
          end
        end
      end
      prev_rdy = readyout;
    end
  end

  initial begin
    int c1;
    int c2;
    int hits;
    int cyc;
    n_cmp    = 0;
    n_fail   = 0;
    prev_rdy = 1'b0;
    rst_n    = 1'b0;
    trans    = 1'b0;
    write    = 1'b0;
    waddr    = 8'h00;
    wdata    = 8'h00;
    #12;
    check("rst_readyout", int'(readyout), 0);
    check("rst_rdata", int'(rdata), 0);
    check("rst_err", int'(err), 0);
    check("rst_state", int'(dbg_state), 0);
    @(posedge clock); #1;
    rst_n = 1'b1;

    // Basic memory write/read at zero wait states
    xfer(1'b1, 8'h03, 8'hA5, 8'hA5, 1'b0, 1);
    xfer(1'b0, 8'h03, 8'h00, 8'hA5, 1'b0, 1);

    // CTRL upper bits read 0; new wait count applies from the next transfer
    xfer(1'b1, 8'h10, 8'h13, 8'h13, 1'b0, 1);
    xfer(1'b0, 8'h03, 8'h00, 8'hA5, 1'b0, 4);
    xfer(1'b0, 8'h10, 8'h00, 8'h03, 1'b0, 4);
    xfer(1'b1, 8'h10, 8'h00, 8'h00, 1'b0, 4);

    // Unmapped / ID / boundary accesses
    xfer(1'b0, 8'h40, 8'h00, 8'hEE, 1'b1, 1);
    xfer(1'b1, 8'h40, 8'h77, 8'h77, 1'b1, 1);
    xfer(1'b1, 8'h12, 8'h11, 8'h11, 1'b1, 1);
    xfer(1'b0, 8'h12, 8'h00, 8'h5A, 1'b0, 1);
    xfer(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1);
    xfer(1'b1, 8'h0F, 8'h42, 8'h42, 1'b0, 1);
    xfer(1'b0, 8'h0F, 8'h00, 8'h42, 1'b0, 1);
    xfer(1'b0, 8'h13, 8'h00, 8'hEE, 1'b1, 1);
    xfer(1'b0, 8'hFF, 8'h00, 8'hEE, 1'b1, 1);

    // Back-to-back reads with trans held across RESP
    @(posedge clock); #1;
    trans = 1'b1;
    write = 1'b0;
    waddr = 8'h03;
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'hA5});
    c1 = -1;
    c2 = -1;
    hits = 0;
    cyc = 0;
    while (hits < 2 && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
      if (readyout) begin
        hits++;
        if (hits == 1) c1 = cyc;
        else c2 = cyc;
      end
    end
    trans = 1'b0;
    check("b2b_first", c1, 1);
    check("b2b_second", c2, 3);

    // Reset during WAIT: pending write dropped, CTRL back to default
    xfer(1'b1, 8'h10, 8'h05, 8'h05, 1'b0, 1);
    @(posedge clock); #1;
    trans = 1'b1;
    write = 1'b1;
    waddr = 8'h07;
    wdata = 8'h3C;
    repeat (3) @(posedge clock);
    #2;
    check("in_wait_state", int'(dbg_state), 1);
    check("in_wait_ready", int'(readyout), 0);
    rst_n = 1'b0;
    #1;
    check("rst_async_state", int'(dbg_state), 0);
    check("rst_async_ready", int'(readyout), 0);
    trans = 1'b0;
    @(posedge clock); #1;
    rst_n = 1'b1;
    xfer(1'b0, 8'h07, 8'h00, 8'h00, 1'b0, 1);
    xfer(1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 1);

    // XFERCNT wrap, read-before-increment, clear-wins-over-increment
    pulse_reset();
    for (int i = 0; i < 256; i++) xfer(1'b0, 8'h12, 8'h00, 8'h5A, 1'b0, 1);
    xfer(1'b0, 8'h11, 8'h00, 8'h00, 1'b0, 1);
    xfer(1'b0, 8'h11, 8'h00, 8'h01, 1'b0, 1);
    xfer(1'b1, 8'h11, 8'h99, 8'h99, 1'b0, 1);
    xfer(1'b0, 8'h11, 8'h00, 8'h00, 1'b0, 1);

    // Drain the scoreboard
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(posedge clock);
      cyc++;
    end
    repeat (2) @(posedge clock);
    check("drain_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
